l2_pmem_adaptor: RTL and testbench

- Responder for the L2 controller's physical-memory handshake (pmem_read/pmem_write/pmem_resp).
- Accepts one 256-bit cacheline read or write request and converts it to a 4-beat, 64-bit burst on the main-memory bus.
- Assembles read lines from bus beats; slices write lines into beats.
- Sits between the L2 datapath/controller and the DRAM/memory model.

---
 rtl/rv32i_types.sv | 20 ++
 rtl/l2_line_buffer.sv | 31 +++
 rtl/l2_pmem_adaptor.sv | 174 +++++++++++++++++
 tb/tb_l2_pmem_adaptor.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I types: L2 physical-memory adaptor state, line and beat widths.
package rv32i_types;

    localparam int LINE_BITS = 256;
    localparam int BEAT_BITS = 64;
    localparam int BEATS     = LINE_BITS / BEAT_BITS;
    localparam int CNT_BITS  = $clog2(BEATS);

    typedef logic [LINE_BITS-1:0] cacheline_t;
    typedef logic [BEAT_BITS-1:0] beat_t;
    typedef logic [CNT_BITS-1:0]  beat_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        RD_BURST,
        WR_BURST,
        RESP
    } pmem_state_e;

endpackage

// File: rtl/l2_line_buffer.sv
// Cacheline register with full-line load and beat-indexed write/read slices.
module l2_line_buffer
    import rv32i_types::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  cacheline_t line_i,
    input  logic       beat_we_i,
    input  beat_idx_t  idx_i,
    input  beat_t      beat_i,
    output cacheline_t line_o,
    output beat_t      beat_o
);

    cacheline_t line_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            line_q <= '0;
        end else if (load_i) begin
            line_q <= line_i;
        end else if (beat_we_i) begin
            line_q[idx_i*BEAT_BITS +: BEAT_BITS] <= beat_i;
        end
    end

    assign line_o = line_q;
    assign beat_o = line_q[idx_i*BEAT_BITS +: BEAT_BITS];

endmodule

// File: rtl/l2_pmem_adaptor.sv
// L2 pmem handshake to 4-beat 64-bit burst bus; line read/write adaptor.
// Optional watchdog abort with sticky pmem_err: define L2_PMEM_TIMEOUT_EN.
module l2_pmem_adaptor
    import rv32i_types::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pmem_read,
    input  logic        pmem_write,
    input  logic [31:0] pmem_address,
    input  cacheline_t  pmem_wdata,
    output cacheline_t  pmem_rdata,
    output logic        pmem_resp,
    output logic [31:0] burst_address,
    output logic        burst_read,
    output logic        burst_write,
    output beat_t       burst_wdata,
    input  beat_t       burst_rdata,
    input  logic        burst_resp,
    output logic        pmem_err
);

    localparam beat_idx_t LAST = beat_idx_t'(BEATS - 1);

    pmem_state_e state_q;
    beat_idx_t   cnt_q;
    logic        resp_q;
    logic        rd_q;
    logic        wr_q;
    logic [31:0] addr_q;
    cacheline_t  rdata_q;

    logic        accept;
    logic        buf_we;
    logic        timeout;
    cacheline_t  buf_src;
    cacheline_t  buf_line;
    cacheline_t  merged;
    beat_t       buf_beat;

    assign accept  = (state_q == IDLE) && (pmem_write || pmem_read);
    assign buf_we  = (state_q == RD_BURST) && burst_resp;
    // Reads start from the last delivered line so aborted slices keep it.
    assign buf_src = pmem_write ? pmem_wdata : rdata_q;

    l2_line_buffer u_buf (
        .clk       (clk),
        .rst       (rst),
        .load_i    (accept),
        .line_i    (buf_src),
        .beat_we_i (buf_we),
        .idx_i     (cnt_q),
        .beat_i    (burst_rdata),
        .line_o    (buf_line),
        .beat_o    (buf_beat)
    );

    always_comb begin
        merged = buf_line;
        if (burst_resp) begin
            merged[cnt_q*BEAT_BITS +: BEAT_BITS] = burst_rdata;
        end
    end

`ifdef L2_PMEM_TIMEOUT_EN
    localparam int WD_BITS = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_BITS-1:0] WD_LAST =
        WD_BITS'(TIMEOUT_CYCLES - 1);

    logic [WD_BITS-1:0] wd_q;
    logic               err_q;
    logic               in_burst;

    assign in_burst = (state_q == RD_BURST) ||
                      (state_q == WR_BURST);
    assign timeout  = in_burst && !burst_resp &&
                      (wd_q == WD_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            if (!in_burst || burst_resp) begin
                wd_q <= '0;
            end else if (!timeout) begin
                wd_q <= wd_q + 1'b1;
            end
            if (timeout) begin
                err_q <= 1'b1;
            end
        end
    end

    assign pmem_err = err_q;
`else
    assign timeout  = 1'b0;
    assign pmem_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            resp_q  <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            rdata_q <= '0;
        end else begin
            resp_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (pmem_write) begin
                        addr_q  <= {pmem_address[31:5], 5'b0};
                        wr_q    <= 1'b1;
                        state_q <= WR_BURST;
                    end else if (pmem_read) begin
                        addr_q  <= {pmem_address[31:5], 5'b0};
                        rd_q    <= 1'b1;
                        state_q <= RD_BURST;
                    end
                end
                RD_BURST: begin
                    if (burst_resp) begin
                        if (cnt_q == LAST) begin
                            rd_q    <= 1'b0;
                            resp_q  <= 1'b1;
                            rdata_q <= merged;
                            state_q <= RESP;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end else if (timeout) begin
                        rd_q    <= 1'b0;
                        resp_q  <= 1'b1;
                        rdata_q <= merged;
                        state_q <= RESP;
                    end
                end
                WR_BURST: begin
                    if (burst_resp) begin
                        if (cnt_q == LAST) begin
                            wr_q    <= 1'b0;
                            resp_q  <= 1'b1;
                            state_q <= RESP;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end else if (timeout) begin
                        wr_q    <= 1'b0;
                        resp_q  <= 1'b1;
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign pmem_rdata    = rdata_q;
    assign pmem_resp     = resp_q;
    assign burst_address = addr_q;
    assign burst_read    = rd_q;
    assign burst_write   = wr_q;
    assign burst_wdata   = buf_beat;

endmodule

// File: tb/tb_l2_pmem_adaptor.sv
// Directed bench for l2_pmem_adaptor with a transaction-level reference model.
module tb_l2_pmem_adaptor;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         pmem_read = 1'b0;
    logic         pmem_write = 1'b0;
    logic [31:0]  pmem_address = '0;
    logic [255:0] pmem_wdata = '0;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;
    logic [31:0]  burst_address;
    logic         burst_read;
    logic         burst_write;
    logic [63:0]  burst_wdata;
    logic [63:0]  burst_rdata = '0;
    logic         burst_resp = 1'b0;
    logic         pmem_err;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    l2_pmem_adaptor dut (
        .clk           (clk),
        .rst           (rst),
        .pmem_read     (pmem_read),
        .pmem_write    (pmem_write),
        .pmem_address  (pmem_address),
        .pmem_wdata    (pmem_wdata),
        .pmem_rdata    (pmem_rdata),
        .pmem_resp     (pmem_resp),
        .burst_address (burst_address),
        .burst_read    (burst_read),
        .burst_write   (burst_write),
        .burst_wdata   (burst_wdata),
        .burst_rdata   (burst_rdata),
        .burst_resp    (burst_resp),
        .pmem_err      (pmem_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm,
                       input logic [255:0] act,
                       input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    // Reference model: one outstanding line transaction, beats counted.
    bit          m_rd, m_wr, m_resp;
    int          m_beats;
    logic [31:0] m_addr;
    logic [63:0] m_line [4];
    logic [63:0] m_out  [4];
    logic [63:0] m_wl   [4];

    function automatic logic [255:0] m_out_line();
        return {m_out[3], m_out[2], m_out[1], m_out[0]};
    endfunction

    initial begin
        m_rd = 0; m_wr = 0; m_resp = 0; m_beats = 0; m_addr = '0;
        for (int i = 0; i < 4; i++) begin
            m_line[i] = '0; m_out[i] = '0; m_wl[i] = '0;
        end
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst) begin
                m_rd = 0; m_wr = 0; m_resp = 0; m_beats = 0;
                m_addr = '0;
                for (int i = 0; i < 4; i++) m_out[i] = '0;
            end else if (m_resp) begin
                m_resp = 0;
            end else if (m_rd || m_wr) begin
                if (burst_resp) begin
                    if (m_rd) m_line[m_beats] = burst_rdata;
                    m_beats++;
                    if (m_beats == 4) begin
                        if (m_rd)
                            for (int i = 0; i < 4; i++)
                                m_out[i] = m_line[i];
                        m_rd = 0; m_wr = 0; m_resp = 1; m_beats = 0;
                    end
                end
            end else if (pmem_write) begin
                m_wr = 1;
                m_addr = {pmem_address[31:5], 5'b0};
                for (int i = 0; i < 4; i++)
                    m_wl[i] = pmem_wdata[i*64 +: 64];
            end else if (pmem_read) begin
                m_rd = 1;
                m_addr = {pmem_address[31:5], 5'b0};
                for (int i = 0; i < 4; i++) m_line[i] = m_out[i];
            end
            @(negedge clk);
            chk("m_burst_read", burst_read, m_rd);
            chk("m_burst_write", burst_write, m_wr);
            chk("m_pmem_resp", pmem_resp, m_resp);
            chk("m_burst_address", burst_address, m_addr);
            chk("m_pmem_rdata", pmem_rdata, m_out_line());
            chk("m_pmem_err", pmem_err, 1'b0);
            if (m_wr) chk("m_burst_wdata", burst_wdata, m_wl[m_beats]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [63:0] bb [4];
    logic [63:0] ew [4];

    task automatic bus_beats(input int stall_at,
                             input int stall_len,
                             input bit wr);
        for (int i = 0; i < 4; i++) begin
            if (i == stall_at) begin
                repeat (stall_len) begin
                    burst_resp = 1'b0;
                    tick();
                    if (wr) chk("stall_wdata", burst_wdata, ew[i]);
                    chk("stall_resp", pmem_resp, 1'b0);
                end
            end
            burst_resp = 1'b1;
            burst_rdata = bb[i];
            if (wr) chk("wdata_beat", burst_wdata, ew[i]);
            tick();
        end
        burst_resp = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a,
                           input int stall_at,
                           input int stall_len,
                           output int lat);
        int st;
        pmem_read = 1'b1;
        pmem_address = a;
        st = cyc;
        tick();
        bus_beats(stall_at, stall_len, 1'b0);
        lat = cyc - st + 1;
        chk("rd_resp_hi", pmem_resp, 1'b1);
        pmem_read = 1'b0;
        tick();
        chk("rd_resp_lo", pmem_resp, 1'b0);
    endtask

    logic [255:0] l1, l2, w1;
    int lat;

    initial begin
        rst = 1'b0;
        tick();
        tick();
        chk("rst_resp", pmem_resp, 1'b0);
        chk("rst_rd", burst_read, 1'b0);
        chk("rst_wr", burst_write, 1'b0);
        chk("rst_addr", burst_address, 32'h0);
        chk("rst_wdata", burst_wdata, 64'h0);
        chk("rst_rdata", pmem_rdata, 256'h0);
        rst = 1'b1;
        tick();

        bb[0] = 64'h1111_1111_1111_1111;
        bb[1] = 64'h2222_2222_2222_2222;
        bb[2] = 64'h3333_3333_3333_3333;
        bb[3] = 64'h4444_4444_4444_4444;
        l1 = {bb[3], bb[2], bb[1], bb[0]};
        do_read(32'h0000_1234, -1, 0, lat);
        chk("rd_latency", lat, 6);
        chk("rd_addr", burst_address, 32'h0000_1220);
        chk("rd_line", pmem_rdata, l1);

        ew[0] = 64'hAAAA_0000_AAAA_0000;
        ew[1] = 64'hBBBB_1111_BBBB_1111;
        ew[2] = 64'hCCCC_2222_CCCC_2222;
        ew[3] = 64'hDDDD_3333_DDDD_3333;
        w1 = {ew[3], ew[2], ew[1], ew[0]};
        pmem_write = 1'b1;
        pmem_address = 32'h8000_0040;
        pmem_wdata = w1;
        tick();
        chk("wr_active", burst_write, 1'b1);
        chk("wr_addr", burst_address, 32'h8000_0040);
        bus_beats(-1, 0, 1'b1);
        chk("wr_resp_hi", pmem_resp, 1'b1);
        pmem_write = 1'b0;
        tick();
        chk("wr_resp_lo", pmem_resp, 1'b0);
        chk("wr_rdata_kept", pmem_rdata, l1);

        burst_resp = 1'b1;
        burst_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
        tick();
        tick();
        burst_resp = 1'b0;
        chk("idle_resp_ign", burst_read, 1'b0);
        chk("idle_rdata", pmem_rdata, l1);

        pmem_write = 1'b1;
        pmem_read = 1'b1;
        pmem_address = 32'h0000_3010;
        pmem_wdata = ~w1;
        for (int i = 0; i < 4; i++) ew[i] = ~w1[i*64 +: 64];
        tick();
        chk("both_wr_first", burst_write, 1'b1);
        chk("both_no_rd", burst_read, 1'b0);
        bus_beats(-1, 0, 1'b1);
        chk("both_wr_resp", pmem_resp, 1'b1);
        pmem_write = 1'b0;
        tick();
        chk("both_idle_rd", burst_read, 1'b0);
        tick();
        chk("both_rd_accept", burst_read, 1'b1);
        chk("both_rd_addr", burst_address, 32'h0000_3000);
        bb[0] = 64'h0123_4567_89AB_CDEF;
        bb[1] = 64'h5555_6666_7777_8888;
        bb[2] = 64'h9999_AAAA_BBBB_CCCC;
        bb[3] = 64'hFEDC_BA98_7654_3210;
        l2 = {bb[3], bb[2], bb[1], bb[0]};
        bus_beats(-1, 0, 1'b0);
        chk("both_rd_resp", pmem_resp, 1'b1);
        pmem_read = 1'b0;
        tick();
        chk("both_rd_line", pmem_rdata, l2);

        bb[0] = 64'h0A0A_0A0A_0A0A_0A0A;
        bb[1] = 64'h0B0B_0B0B_0B0B_0B0B;
        bb[2] = 64'h0C0C_0C0C_0C0C_0C0C;
        bb[3] = 64'h0D0D_0D0D_0D0D_0D0D;
        do_read(32'h0000_4000, 2, 3, lat);
        chk("stall_latency", lat, 9);
        chk("stall_line", pmem_rdata,
            {bb[3], bb[2], bb[1], bb[0]});

        pmem_read = 1'b1;
        pmem_address = 32'h0000_5000;
        tick();
        for (int i = 0; i < 2; i++) begin
            burst_resp = 1'b1;
            burst_rdata = 64'hEEEE_EEEE_0000_0000 | 64'(i);
            tick();
        end
        burst_resp = 1'b0;
        rst = 1'b0;
        pmem_read = 1'b0;
        tick();
        chk("rst_mid_rd", burst_read, 1'b0);
        chk("rst_mid_resp", pmem_resp, 1'b0);
        chk("rst_mid_rdata", pmem_rdata, 256'h0);
        rst = 1'b1;
        tick();
        bb[0] = 64'h1010_2020_3030_4040;
        bb[1] = 64'h5050_6060_7070_8080;
        bb[2] = 64'h9090_A0A0_B0B0_C0C0;
        bb[3] = 64'hD0D0_E0E0_F0F0_0101;
        do_read(32'h0000_5000, -1, 0, lat);
        chk("post_rst_lat", lat, 6);
        chk("post_rst_line", pmem_rdata,
            {64'hD0D0_E0E0_F0F0_0101, 64'h9090_A0A0_B0B0_C0C0,
             64'h5050_6060_7070_8080, 64'h1010_2020_3030_4040});

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL sim_timeout act=running exp=finished");
        $fatal(1, "bench time limit");
    end

endmodule
